// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared definitions for the CAN receive-side classifier and its helpers:
// FSM state encoding, frame_type codes and the field widths of the
// arbitration and control fields.
// ---------------------------------------------------------------------------
package can_pkg;

    localparam int BASE_ID_W = 11;
    localparam int EXT_ID_W  = 18;
    localparam int ID_W      = BASE_ID_W + EXT_ID_W;
    localparam int DLC_W     = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BASE_ID,
        ST_RTR_SRR,
        ST_IDE,
        ST_EXT_ID,
        ST_RTR_RRS,
        ST_FDF,
        ST_RES,
        ST_BRS,
        ST_ESI,
        ST_DLC,
        ST_DONE
    } state_e;

    localparam logic [1:0] FT_CLASSIC_DATA   = 2'b00;
    localparam logic [1:0] FT_CLASSIC_REMOTE = 2'b01;
    localparam logic [1:0] FT_FD_DATA        = 2'b10;

endpackage

// File: rtl/can_dlc_to_len.sv
// ---------------------------------------------------------------------------
// can_dlc_to_len
// Purely combinational DLC -> payload byte count mapping, shared by the
// receiver classifier and the transmitter.
//   dlc   in  4      raw data length code
//   is_fd in  1      1 = CAN FD length table, 0 = classic (clamped to 8)
//   len   out LEN_W  payload length in bytes
// ---------------------------------------------------------------------------
module can_dlc_to_len
    import can_pkg::*;
#(
    parameter int LEN_W = 7
) (
    input  logic [DLC_W-1:0] dlc,
    input  logic             is_fd,
    output logic [LEN_W-1:0] len
);

    logic [6:0] len7;

    always_comb begin
        len7 = 7'd0;
        if (dlc <= 4'd8) begin
            len7 = {3'b000, dlc};
        end else if (!is_fd) begin
            len7 = 7'd8;
        end else begin
            case (dlc)
                4'd9:    len7 = 7'd12;
                4'd10:   len7 = 7'd16;
                4'd11:   len7 = 7'd20;
                4'd12:   len7 = 7'd24;
                4'd13:   len7 = 7'd32;
                4'd14:   len7 = 7'd48;
                default: len7 = 7'd64;
            endcase
        end
        len = LEN_W'(len7);
    end

endmodule

// File: rtl/can_frame_classifier.sv
// ---------------------------------------------------------------------------
// can_frame_classifier
// Walks the de-stuffed arbitration and control fields of a CAN frame on
// sample-point strobes, then publishes the frame classification together
// with the payload length for the data-field/CRC receiver.
//
// Build option: define CAN_FD_EN to accept FD frames (FDF=1). Without it an
// FDF=1 bit is a form error and is_fd/brs/esi stay 0.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   sp             sample-point strobe (non-stuff bits only)
//   rx_bit         de-stuffed bit, valid with sp
//   sof            start-of-frame marker on the SOF bit's sp
//   abort          cancels the frame in progress (highest priority)
//   frame_valid    one-clk pulse, classification outputs updated
//   frame_type     00 classic data, 01 classic remote, 10 FD data
//   is_ext, is_fd, brs, esi, id, dlc, data_len   published fields
//   form_err       one-clk pulse on an illegal control field
//   busy           frame being decoded
// ---------------------------------------------------------------------------
module can_frame_classifier
    import can_pkg::*;
#(
    parameter int SUPPORT_EXT = 1,
    parameter int LEN_W       = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sp,
    input  logic             rx_bit,
    input  logic             sof,
    input  logic             abort,
    output logic             frame_valid,
    output logic [1:0]       frame_type,
    output logic             is_ext,
    output logic             is_fd,
    output logic             brs,
    output logic             esi,
    output logic [ID_W-1:0]  id,
    output logic [DLC_W-1:0] dlc,
    output logic [LEN_W-1:0] data_len,
    output logic             form_err,
    output logic             busy
);

`ifdef CAN_FD_EN
    localparam logic FD_EN = 1'b1;
`else
    localparam logic FD_EN = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;

    // Working capture of the frame currently being walked
    logic [BASE_ID_W-1:0]   cap_base_q, cap_base_d;
    logic [EXT_ID_W-1:0]    cap_ext_q, cap_ext_d;
    logic                   cap_ide_q, cap_ide_d;
    logic                   cap_rtr0_q, cap_rtr0_d;
    logic                   cap_rtr_q, cap_rtr_d;
    logic                   cap_fdf_q, cap_fdf_d;
    logic                   cap_brs_q, cap_brs_d;
    logic                   cap_esi_q, cap_esi_d;
    logic [DLC_W-1:0]       cap_dlc_q, cap_dlc_d;

    // Published outputs
    logic                   frame_valid_q, frame_valid_d;
    logic                   form_err_q, form_err_d;
    logic                   busy_q, busy_d;
    logic [1:0]             frame_type_q, frame_type_d;
    logic                   is_ext_q, is_ext_d;
    logic                   is_fd_q, is_fd_d;
    logic                   brs_q, brs_d;
    logic                   esi_q, esi_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [DLC_W-1:0]       dlc_q, dlc_d;
    logic [LEN_W-1:0]       data_len_q, data_len_d;

    logic [LEN_W-1:0]       len_w;
    logic                   start;

    can_dlc_to_len #(.LEN_W(LEN_W)) u_dlc_to_len (
        .dlc   (cap_dlc_q),
        .is_fd (cap_fdf_q),
        .len   (len_w)
    );

    assign start = sof & sp;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cap_base_d    = cap_base_q;
        cap_ext_d     = cap_ext_q;
        cap_ide_d     = cap_ide_q;
        cap_rtr0_d    = cap_rtr0_q;
        cap_rtr_d     = cap_rtr_q;
        cap_fdf_d     = cap_fdf_q;
        cap_brs_d     = cap_brs_q;
        cap_esi_d     = cap_esi_q;
        cap_dlc_d     = cap_dlc_q;
        frame_valid_d = 1'b0;
        form_err_d    = 1'b0;
        busy_d        = busy_q;
        frame_type_d  = frame_type_q;
        is_ext_d      = is_ext_q;
        is_fd_d       = is_fd_q;
        brs_d         = brs_q;
        esi_d         = esi_q;
        id_d          = id_q;
        dlc_d         = dlc_q;
        data_len_d    = data_len_q;

        if (abort) begin
            // Outputs keep the last published frame; only control is cleared
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            // DONE publishes unconditionally; a sof in this clk is honoured below
            if (state_q == ST_DONE) begin
                frame_valid_d = 1'b1;
                if (cap_fdf_q) begin
                    frame_type_d = FT_FD_DATA;
                end else if (cap_rtr_q) begin
                    frame_type_d = FT_CLASSIC_REMOTE;
                end else begin
                    frame_type_d = FT_CLASSIC_DATA;
                end
                is_ext_d   = cap_ide_q;
                is_fd_d    = cap_fdf_q;
                brs_d      = cap_fdf_q & cap_brs_q;
                esi_d      = cap_fdf_q & cap_esi_q;
                id_d       = cap_ide_q ? {cap_base_q, cap_ext_q}
                                       : {cap_base_q, {EXT_ID_W{1'b0}}};
                dlc_d      = cap_dlc_q;
                // cap_rtr is forced low for FD frames, so this only hits remotes
                data_len_d = cap_rtr_q ? '0 : len_w;
            end

            if (start) begin
                state_d   = ST_BASE_ID;
                cnt_d     = 5'd0;
                busy_d    = 1'b1;
                cap_ide_d = 1'b0;
                cap_rtr_d = 1'b0;
                cap_fdf_d = 1'b0;
                cap_brs_d = 1'b0;
                cap_esi_d = 1'b0;
            end else if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end else if (sp) begin
                case (state_q)
                    ST_BASE_ID: begin
                        cap_base_d = {cap_base_q[BASE_ID_W-2:0], rx_bit};
                        if (cnt_q == 5'(BASE_ID_W - 1)) begin
                            state_d = ST_RTR_SRR;
                            cnt_d   = 5'd0;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                    ST_RTR_SRR: begin
                        cap_rtr0_d = rx_bit;
                        state_d    = ST_IDE;
                    end
                    ST_IDE: begin
                        cap_ide_d = rx_bit;
                        if (rx_bit) begin
                            if (SUPPORT_EXT != 0) begin
                                state_d = ST_EXT_ID;
                                cnt_d   = 5'd0;
                            end else begin
                                form_err_d = 1'b1;
                                state_d    = ST_IDLE;
                                busy_d     = 1'b0;
                            end
                        end else begin
                            cap_rtr_d = cap_rtr0_q;
                            state_d   = ST_FDF;
                        end
                    end
                    ST_EXT_ID: begin
                        cap_ext_d = {cap_ext_q[EXT_ID_W-2:0], rx_bit};
                        if (cnt_q == 5'(EXT_ID_W - 1)) begin
                            state_d = ST_RTR_RRS;
                            cnt_d   = 5'd0;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                    ST_RTR_RRS: begin
                        // The earlier SRR bit is discarded; this is the real RTR
                        cap_rtr_d = rx_bit;
                        state_d   = ST_FDF;
                    end
                    ST_FDF: begin
                        cnt_d = 5'd0;
                        if (rx_bit) begin
                            if (FD_EN) begin
                                cap_fdf_d = 1'b1;
                                cap_rtr_d = 1'b0;
                                state_d   = ST_RES;
                            end else begin
                                form_err_d = 1'b1;
                                state_d    = ST_IDLE;
                                busy_d     = 1'b0;
                            end
                        end else begin
                            // Base frame: this bit was r0. Extended: r0 follows.
                            cap_fdf_d = 1'b0;
                            state_d   = cap_ide_q ? ST_RES : ST_DLC;
                        end
                    end
                    ST_RES: begin
                        // Reserved bit value is don't-care
                        cnt_d   = 5'd0;
                        state_d = cap_fdf_q ? ST_BRS : ST_DLC;
                    end
                    ST_BRS: begin
                        cap_brs_d = rx_bit;
                        state_d   = ST_ESI;
                    end
                    ST_ESI: begin
                        cap_esi_d = rx_bit;
                        cnt_d     = 5'd0;
                        state_d   = ST_DLC;
                    end
                    ST_DLC: begin
                        cap_dlc_d = {cap_dlc_q[DLC_W-2:0], rx_bit};
                        if (cnt_q == 5'(DLC_W - 1)) begin
                            state_d = ST_DONE;
                            cnt_d   = 5'd0;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 5'd0;
            cap_base_q    <= '0;
            cap_ext_q     <= '0;
            cap_ide_q     <= 1'b0;
            cap_rtr0_q    <= 1'b0;
            cap_rtr_q     <= 1'b0;
            cap_fdf_q     <= 1'b0;
            cap_brs_q     <= 1'b0;
            cap_esi_q     <= 1'b0;
            cap_dlc_q     <= '0;
            frame_valid_q <= 1'b0;
            form_err_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_type_q  <= 2'b00;
            is_ext_q      <= 1'b0;
            is_fd_q       <= 1'b0;
            brs_q         <= 1'b0;
            esi_q         <= 1'b0;
            id_q          <= '0;
            dlc_q         <= '0;
            data_len_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cap_base_q    <= cap_base_d;
            cap_ext_q     <= cap_ext_d;
            cap_ide_q     <= cap_ide_d;
            cap_rtr0_q    <= cap_rtr0_d;
            cap_rtr_q     <= cap_rtr_d;
            cap_fdf_q     <= cap_fdf_d;
            cap_brs_q     <= cap_brs_d;
            cap_esi_q     <= cap_esi_d;
            cap_dlc_q     <= cap_dlc_d;
            frame_valid_q <= frame_valid_d;
            form_err_q    <= form_err_d;
            busy_q        <= busy_d;
            frame_type_q  <= frame_type_d;
            is_ext_q      <= is_ext_d;
            is_fd_q       <= is_fd_d;
            brs_q         <= brs_d;
            esi_q         <= esi_d;
            id_q          <= id_d;
            dlc_q         <= dlc_d;
            data_len_q    <= data_len_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign form_err    = form_err_q;
    assign busy        = busy_q;
    assign frame_type  = frame_type_q;
    assign is_ext      = is_ext_q;
    assign is_fd       = is_fd_q;
    assign brs         = brs_q;
    assign esi         = esi_q;
    assign id          = id_q;
    assign dlc         = dlc_q;
    assign data_len    = data_len_q;

endmodule

// File: tb/tb_can_frame_classifier.sv
// ---------------------------------------------------------------------------
// tb_can_frame_classifier
// Drives serialized CAN headers into can_frame_classifier and compares every
// cycle against a frame-level model (expected fields derived from the frame
// descriptor, not from the bit walk). Honours CAN_FD_EN like the design.
// ---------------------------------------------------------------------------
module tb_can_frame_classifier;

    localparam int LEN_W       = 7;
    localparam int SUPPORT_EXT = 1;
`ifdef CAN_FD_EN
    localparam bit FD_EN = 1'b1;
`else
    localparam bit FD_EN = 1'b0;
`endif
    localparam int FD_LEN [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 24, 32, 48, 64};

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic        rtr;
        logic        fd;
        logic        brs;
        logic        esi;
        logic        srr;
        logic        r0;
        logic        res;
        logic [3:0]  dlc;
    } frame_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              sp = 1'b0;
    logic              rx_bit = 1'b0;
    logic              sof = 1'b0;
    logic              abort = 1'b0;
    logic              frame_valid;
    logic [1:0]        frame_type;
    logic              is_ext;
    logic              is_fd;
    logic              brs;
    logic              esi;
    logic [28:0]       id;
    logic [3:0]        dlc;
    logic [LEN_W-1:0]  data_len;
    logic              form_err;
    logic              busy;
    logic [45:0]       dut_fields;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          fv_at = -1;
    int          fe_at = -1;
    int          fv_seen = 0;
    int          fe_seen = 0;
    logic [45:0] pending = '0;
    logic [45:0] pub = '0;
    bit          fbits[$];
    int          err_idx;

    can_frame_classifier #(.SUPPORT_EXT(SUPPORT_EXT), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sp          (sp),
        .rx_bit      (rx_bit),
        .sof         (sof),
        .abort       (abort),
        .frame_valid (frame_valid),
        .frame_type  (frame_type),
        .is_ext      (is_ext),
        .is_fd       (is_fd),
        .brs         (brs),
        .esi         (esi),
        .id          (id),
        .dlc         (dlc),
        .data_len    (data_len),
        .form_err    (form_err),
        .busy        (busy)
    );

    assign dut_fields = {frame_type, is_ext, is_fd, brs, esi, id, dlc, data_len};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected published fields of a correctly formed frame
    function automatic logic [45:0] model(input frame_t f);
        logic       rtr_eff;
        logic [6:0] len;
        logic [1:0] ft;
        logic [28:0] idv;
        rtr_eff = f.fd ? 1'b0 : f.rtr;
        if (rtr_eff)   len = 7'd0;
        else if (f.fd) len = 7'(FD_LEN[f.dlc]);
        else           len = (f.dlc > 4'd8) ? 7'd8 : {3'b000, f.dlc};
        ft  = f.fd ? 2'd2 : (rtr_eff ? 2'd1 : 2'd0);
        idv = f.ide ? f.id : {f.id[28:18], 18'd0};
        return {ft, f.ide, f.fd, f.fd & f.brs, f.fd & f.esi, idv, f.dlc, len};
    endfunction

    // Serialize the frame header and note where it becomes illegal (if anywhere)
    task automatic build(input frame_t f);
        int fdf_idx;
        fbits.delete();
        fbits.push_back(1'b0);
        for (int i = 10; i >= 0; i--) fbits.push_back(f.id[18+i]);
        if (!f.ide) begin
            fbits.push_back(f.rtr);
            fbits.push_back(1'b0);
        end else begin
            fbits.push_back(f.srr);
            fbits.push_back(1'b1);
            for (int i = 17; i >= 0; i--) fbits.push_back(f.id[i]);
            fbits.push_back(f.rtr);
        end
        fdf_idx = fbits.size();
        fbits.push_back(f.fd);
        if (f.fd) begin
            fbits.push_back(f.res);
            fbits.push_back(f.brs);
            fbits.push_back(f.esi);
        end else if (f.ide) begin
            fbits.push_back(f.r0);
        end
        for (int i = 3; i >= 0; i--) fbits.push_back(f.dlc[i]);
        err_idx = -1;
        if (f.ide && SUPPORT_EXT == 0) err_idx = 13;
        else if (f.fd && !FD_EN)       err_idx = fdf_idx;
    endtask

    task automatic send_bit(input logic b, input logic s);
        sp = 1'b1; rx_bit = b; sof = s;
        @(negedge clk);
        sp = 1'b0; sof = 1'b0; rx_bit = 1'($urandom);
    endtask

    // nbits < 0 sends the whole header; slow inserts 50-clk sp gaps
    task automatic send_frame(input frame_t f, input int gapmax, input int nbits, input bit slow);
        int n;
        int gap;
        build(f);
        n = (nbits < 0) ? fbits.size() : nbits;
        for (int i = 0; i < n; i++) begin
            if (slow) gap = (i % 6 == 5) ? 50 : 0;
            else      gap = (gapmax == 0) ? 0 : int'($urandom_range(gapmax, 0));
            repeat (gap) @(negedge clk);
            if (i == err_idx) fe_at = cyc + 1;
            if (i == fbits.size() - 1 && err_idx < 0) begin
                pending = model(f);
                fv_at   = cyc + 2;
            end
            send_bit(fbits[i], (i == 0));
            if (i == 0) chk("busy_after_sof", busy, 1);
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        f.id  = 29'($urandom);
        f.ide = 1'($urandom);
        f.rtr = 1'($urandom);
        f.fd  = ($urandom_range(2, 0) == 0);
        f.brs = 1'($urandom);
        f.esi = 1'($urandom);
        f.srr = 1'($urandom);
        f.r0  = 1'($urandom);
        f.res = 1'($urandom);
        f.dlc = 4'($urandom);
        return f;
    endfunction

    // Per-cycle comparison against the model
    initial begin
        logic exp_fv;
        logic exp_fe;
        forever begin
            @(negedge clk);
            if (!reset_n) pub = '0;
            exp_fv = (cyc == fv_at);
            exp_fe = (cyc == fe_at);
            if (exp_fv) pub = pending;
            if (frame_valid) fv_seen++;
            if (form_err) fe_seen++;
            chk("frame_valid", frame_valid, exp_fv);
            chk("form_err", form_err, exp_fe);
            chk("fields", dut_fields, pub);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        int     snap;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_fields", dut_fields, 0);
        chk("reset_busy", busy, 0);
        chk("reset_valid", frame_valid, 0);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // Base classic remote, ID 0x123, DLC 4
        f = '0; f.id = {11'h123, 18'h0}; f.rtr = 1'b1; f.dlc = 4'd4;
        send_frame(f, 2, -1, 1'b0);
        @(negedge clk);
        chk("remote_valid", frame_valid, 1);
        chk("remote_type", frame_type, 2'b01);
        chk("remote_len", data_len, 0);
        chk("remote_id", id, 29'h48C0000);
        chk("remote_ext", is_ext, 0);
        chk("remote_busy", busy, 0);

        // Extended FD with BRS, DLC 13
        snap = fe_seen;
        f = '0; f.id = 29'h1ABCDEF0; f.ide = 1'b1; f.srr = 1'b1; f.rtr = 1'b1;
        f.fd = 1'b1; f.brs = 1'b1; f.dlc = 4'hD;
        send_frame(f, 1, -1, 1'b0);
        @(negedge clk);
`ifdef CAN_FD_EN
        chk("fd_valid", frame_valid, 1);
        chk("fd_type", frame_type, 2'b10);
        chk("fd_brs", brs, 1);
        chk("fd_len", data_len, 32);
        chk("fd_ext", is_ext, 1);
        chk("fd_id", id, 29'h1ABCDEF0);
`else
        #1;
        chk("nofd_form_err_count", fe_seen - snap, 1);
        chk("nofd_valid", frame_valid, 0);
        chk("nofd_busy", busy, 0);
`endif

        // Classic DLC clamp
        f = '0; f.id = {11'h055, 18'h0}; f.dlc = 4'hF;
        send_frame(f, 2, -1, 1'b0);
        @(negedge clk);
        chk("clamp_len", data_len, 8);
        chk("clamp_type", frame_type, 2'b00);

        // Abort on EXT_ID bit 7 with simultaneous sof
        snap = fv_seen;
        f = '0; f.id = 29'h0ABCDE1; f.ide = 1'b1; f.dlc = 4'd5;
        send_frame(f, 1, 21, 1'b0);
        abort = 1'b1;
        send_bit(1'b1, 1'b1);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        for (int i = 0; i < 6; i++) send_bit(1'($urandom), 1'b0);
        #1;
        chk("abort_no_valid", fv_seen - snap, 0);
        chk("abort_keeps_len", data_len, 8);
        chk("abort_keeps_id", id, {11'h055, 18'h0});
        send_frame(f, 1, -1, 1'b0);
        @(negedge clk);
        chk("after_abort_len", data_len, 5);
        chk("after_abort_ext", is_ext, 1);
        chk("after_abort_id", id, 29'h0ABCDE1);

        // sof on DLC bit 2 restarts; only the second frame is published
        snap = fv_seen;
        f = '0; f.id = {11'h321, 18'h0}; f.dlc = 4'd3;
        send_frame(f, 0, 17, 1'b0);
        f = '0; f.id = {11'h7FF, 18'h0}; f.dlc = 4'd2;
        send_frame(f, 1, -1, 1'b0);
        @(negedge clk);
        #1;
        chk("restart_one_valid", fv_seen - snap, 1);
        chk("restart_len", data_len, 2);
        chk("restart_id", id, 29'h1FFC0000);

        // Long sp gaps
        f = '0; f.id = 29'h1234567; f.ide = 1'b1; f.dlc = 4'd9;
        send_frame(f, 0, -1, 1'b1);
        @(negedge clk);
        chk("slow_len", data_len, 8);
        chk("slow_id", id, 29'h1234567);

        // Asynchronous reset mid-frame
        f = '0; f.id = {11'h0F0, 18'h0}; f.dlc = 4'd6;
        send_frame(f, 0, 10, 1'b0);
        repeat (20) @(negedge clk);
        chk("idle_gap_busy", busy, 1);
        #2 reset_n = 1'b0;
        fv_at = -1; fe_at = -1;
        #1;
        chk("async_rst_fields", dut_fields, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        send_frame(f, 1, -1, 1'b0);
        @(negedge clk);
        chk("post_rst_len", data_len, 6);

        // Randomized frames, occasionally back-to-back into the DONE clk
        for (int k = 0; k < 80; k++) begin
            send_frame(rand_frame(), 3, -1, 1'b0);
        end
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
